modport_sweep: RTL and testbench

// - Synthesizable exhaustive test-vector sweeper for a combinational block with WIDTH inputs and one output.
// - Drives every input combination 0..2**WIDTH-1 in ascending order and waits SETTLE cycles per vector.
// - Samples the block's single output per vector and assembles its full truth table plus a ones count.
// - Sits beside the block under test in self-check and bring-up harnesses.

---
 rtl/modport_sweep.sv | 141 ++++++++++++++
 tb/tb_modport_sweep.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/modport_sweep.sv
// Exhaustive stimulus sweeper: applies vectors 0..2**WIDTH-1 to a one-output block and records its truth table.
// Optional MODPORT_SWEEP_DISPLAY_EN prints each captured vector in simulation.
module modport_sweep #(
    parameter int WIDTH  = 2,
    parameter int SETTLE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  dut_out,
    output logic [WIDTH-1:0]      inputs,
    output logic                  busy,
    output logic                  done,
    output logic                  sample_valid,
    output logic [WIDTH-1:0]      sample_idx,
    output logic                  sample_bit,
    output logic [2**WIDTH-1:0]   truth_table,
    output logic [WIDTH:0]        ones_count
);

    localparam int NVEC = 2**WIDTH;
    localparam int TW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [WIDTH:0]  LAST_IDX   = (WIDTH+1)'(NVEC - 1);
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SETTLE - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t             state_reg;
    logic [WIDTH:0]     index_reg;
    logic [TW-1:0]      timer_reg;
    logic [WIDTH-1:0]   inputs_reg;
    logic               busy_reg;
    logic               done_reg;
    logic               sample_valid_reg;
    logic [WIDTH-1:0]   sample_idx_reg;
    logic               sample_bit_reg;
    logic [WIDTH:0]     ones_count_reg;

    logic start_ok;
    logic capture;

    // A new sweep may only begin from rest; start during a sweep is ignored.
    assign start_ok = start && ((state_reg == S_IDLE) || (state_reg == S_DONE));
    assign capture  = (state_reg == S_SAMPLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg        <= S_IDLE;
            index_reg        <= '0;
            timer_reg        <= '0;
            inputs_reg       <= '0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            sample_valid_reg <= 1'b0;
            sample_idx_reg   <= '0;
            sample_bit_reg   <= 1'b0;
            ones_count_reg   <= '0;
        end else begin
            sample_valid_reg <= 1'b0;
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        inputs_reg     <= '0;
                        index_reg      <= '0;
                        timer_reg      <= '0;
                        ones_count_reg <= '0;
                        done_reg       <= 1'b0;
                        busy_reg       <= 1'b1;
                        state_reg      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    timer_reg <= timer_reg + 1'b1;
                    if (timer_reg == TIMER_LAST) begin
                        state_reg <= S_SAMPLE;
                    end
                end
                S_SAMPLE: begin
                    sample_valid_reg <= 1'b1;
                    sample_idx_reg   <= index_reg[WIDTH-1:0];
                    sample_bit_reg   <= dut_out;
                    ones_count_reg   <= ones_count_reg + {{WIDTH{1'b0}}, dut_out};
                    // Last vector stays on the inputs after completion; no wrap back to 0.
                    if (index_reg == LAST_IDX) begin
                        busy_reg  <= 1'b0;
                        done_reg  <= 1'b1;
                        state_reg <= S_DONE;
                    end else begin
                        index_reg  <= index_reg + 1'b1;
                        inputs_reg <= index_reg[WIDTH-1:0] + 1'b1;
                        timer_reg  <= '0;
                        state_reg  <= S_SETTLE;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    // One capture flop per truth-table entry, cleared when a new sweep starts.
    genvar gi;
    generate
        for (gi = 0; gi < NVEC; gi++) begin : g_tt
            logic tt_bit_reg;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    tt_bit_reg <= 1'b0;
                end else if (start_ok) begin
                    tt_bit_reg <= 1'b0;
                end else if (capture && (index_reg[WIDTH-1:0] == WIDTH'(gi))) begin
                    tt_bit_reg <= dut_out;
                end
            end
            assign truth_table[gi] = tt_bit_reg;
        end
    endgenerate

    assign inputs       = inputs_reg;
    assign busy         = busy_reg;
    assign done         = done_reg;
    assign sample_valid = sample_valid_reg;
    assign sample_idx   = sample_idx_reg;
    assign sample_bit   = sample_bit_reg;
    assign ones_count   = ones_count_reg;

`ifdef MODPORT_SWEEP_DISPLAY_EN
    always @(posedge clk) begin
        if (sample_valid_reg) begin
            $display("Test vector %d applied, output: %b", sample_idx_reg, sample_bit_reg);
        end
    end
`else
    // Display hook compiled out; ports and timing are identical.
`endif

endmodule

// File: tb/tb_modport_sweep.sv
// Self-checking bench: two sweeper instances (WIDTH=2/SETTLE=10 and WIDTH=3/SETTLE=1) driving emulated blocks.
module tb_modport_sweep;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       start_a = 1'b0;
    logic       out_a;
    logic [1:0] in_a;
    logic       busy_a, done_a, sv_a, sb_a;
    logic [1:0] si_a;
    logic [3:0] tt_a;
    logic [2:0] oc_a;

    logic       start_b = 1'b0;
    logic       out_b;
    logic [2:0] in_b;
    logic       busy_b, done_b, sv_b, sb_b;
    logic [2:0] si_b;
    logic [7:0] tt_b;
    logic [3:0] oc_b;

    int         mode_a = 0;
    int         mode_b = 0;
    logic [3:0] lut_a = '0;
    logic [7:0] lut_b = '0;

    int n_cmp = 0;
    int n_err = 0;

    modport_sweep #(.WIDTH(2), .SETTLE(10)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .dut_out(out_a),
        .inputs(in_a), .busy(busy_a), .done(done_a), .sample_valid(sv_a),
        .sample_idx(si_a), .sample_bit(sb_a), .truth_table(tt_a), .ones_count(oc_a)
    );

    modport_sweep #(.WIDTH(3), .SETTLE(1)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .dut_out(out_b),
        .inputs(in_b), .busy(busy_b), .done(done_b), .sample_valid(sv_b),
        .sample_idx(si_b), .sample_bit(sb_b), .truth_table(tt_b), .ones_count(oc_b)
    );

    // Emulated blocks under test: 0=AND, 1=XOR, 2=constant 0, 3=random lookup table.
    function automatic logic f_a(input int v);
        case (mode_a)
            0:       return v == 3;
            1:       return ((v & 1) + ((v >> 1) & 1)) == 1;
            2:       return 1'b0;
            default: return lut_a[v];
        endcase
    endfunction

    function automatic logic f_b(input int v);
        if (mode_b == 0) return 1'b1;
        return lut_b[v];
    endfunction

    always_comb out_a = f_a(int'(in_a));
    always_comb out_b = f_b(int'(in_b));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Full sweep on instance A; poke=1 pulses start mid-sweep and on the final sample edge.
    task automatic run_a(input bit poke);
        logic [3:0] exp_tt;
        int exp_ones, exp_idx, k;
        exp_tt = '0;
        exp_ones = 0;
        for (int i = 0; i < 4; i++) begin
            exp_tt[i] = f_a(i);
            exp_ones += int'(exp_tt[i]);
        end
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        chk("a_start_busy", 64'(busy_a), 64'd1);
        chk("a_start_clear", 64'({done_a, tt_a, oc_a, in_a}), 64'd0);
        exp_idx = 0;
        k = 0;
        while (!done_a && k < 100) begin
            @(posedge clk); #1;
            k++;
            start_a = 1'b0;
            if (poke && (k == 20 || k == 43)) start_a = 1'b1;
            if (sv_a) begin
                chk("a_sample_idx", 64'(si_a), 64'(exp_idx));
                chk("a_sample_bit", 64'(sb_a), 64'(f_a(exp_idx)));
                chk("a_sample_cycle", 64'(k), 64'((exp_idx + 1) * 11));
                exp_idx++;
            end
            chk("a_inputs", 64'(in_a), 64'((exp_idx > 3) ? 3 : exp_idx));
        end
        start_a = 1'b0;
        chk("a_done_seen", 64'(done_a), 64'd1);
        chk("a_done_cycle", 64'(k), 64'd44);
        chk("a_sample_count", 64'(exp_idx), 64'd4);
        chk("a_truth_table", 64'(tt_a), 64'(exp_tt));
        chk("a_ones_count", 64'(oc_a), 64'(exp_ones));
        chk("a_busy_end", 64'(busy_a), 64'd0);
        @(posedge clk); #1;
        chk("a_done_hold", 64'({done_a, sv_a, in_a}), 64'b1_0_11);
        $display("sweep A mode=%0d tt=%b ones=%0d cycles=%0d", mode_a, tt_a, oc_a, k);
    endtask

    task automatic run_b();
        logic [7:0] exp_tt;
        int exp_ones, exp_idx, k;
        exp_tt = '0;
        exp_ones = 0;
        for (int i = 0; i < 8; i++) begin
            exp_tt[i] = f_b(i);
            exp_ones += int'(exp_tt[i]);
        end
        start_b = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("b_start", 64'({busy_b, done_b, tt_b, oc_b, in_b}), 64'h1_0_00_0_0 >> 1 << 1 & 64'h0 | (64'd1 << 16));
        exp_idx = 0;
        k = 0;
        while (!done_b && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (sv_b) begin
                chk("b_sample_idx", 64'(si_b), 64'(exp_idx));
                chk("b_sample_bit", 64'(sb_b), 64'(f_b(exp_idx)));
                exp_idx++;
            end
            chk("b_inputs", 64'(in_b), 64'(((k / 2) > 7) ? 7 : (k / 2)));
        end
        chk("b_done_cycle", 64'(k), 64'd16);
        chk("b_sample_count", 64'(exp_idx), 64'd8);
        chk("b_truth_table", 64'(tt_b), 64'(exp_tt));
        chk("b_ones_count", 64'(oc_b), 64'(exp_ones));
        $display("sweep B mode=%0d tt=%b ones=%0d cycles=%0d", mode_b, tt_b, oc_b, k);
    endtask

    initial begin
        int k;
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("a_reset", 64'({in_a, busy_a, done_a, sv_a, si_a, sb_a, tt_a, oc_a}), 64'd0);
        chk("b_reset", 64'({in_b, busy_b, done_b, sv_b, si_b, sb_b, tt_b, oc_b}), 64'd0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_idle", 64'({busy_a, done_a}), 64'd0);

        mode_a = 0; run_a(1'b0);
        mode_a = 1; run_a(1'b1);
        mode_a = 2; run_a(1'b0);
        repeat (3) begin
            mode_a = 3;
            lut_a = 4'($urandom);
            run_a(1'($urandom_range(0, 1)));
        end

        mode_b = 0; run_b();
        repeat (3) begin
            mode_b = 1;
            lut_b = 8'($urandom);
            run_b();
        end

        // Abort mid-sweep at vector 2, then confirm a clean sweep from vector 0.
        mode_a = 1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        k = 0;
        while (in_a != 2'd2 && k < 60) begin
            @(posedge clk); #1;
            k++;
        end
        chk("a_reach_vec2", 64'(in_a), 64'd2);
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("a_async_reset", 64'({in_a, busy_a, done_a, sv_a, si_a, sb_a, tt_a, oc_a}), 64'd0);
        chk("b_async_reset", 64'({in_b, busy_b, done_b, tt_b, oc_b}), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("a_after_reset", 64'({busy_a, done_a, tt_a, oc_a}), 64'd0);
        mode_a = 3;
        lut_a = 4'($urandom);
        run_a(1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
